uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, one stop bit.
// Outputs are registered; a frame is accepted only from IDLE.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic          tx_n, busy_n, done_n;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shreg   <= 8'd0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_busy <= busy_n;
            tx_done <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        tx_n    = tx;
        busy_n  = tx_busy;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                idx_n  = 3'd0;
                if (tx_start) begin
                    state_n = START;
                    shreg_n = tx_data;
                    // Parity is fixed at acceptance so later tx_data changes cannot leak in
                    par_n   = (^tx_data) ^ PARITY_ODD;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[7:1]};
                end else begin
                    state_n = START;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        idx_n = 3'd0;
                        if (PARITY_EN) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n   = idx + 3'd1;
                        tx_n    = shreg[0];
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end else begin
                    state_n = DATA;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else begin
                    state_n = PARITY;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = STOP;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        // Bit timer restarts at every bit boundary and rests at zero in IDLE
        if (state == IDLE) begin
            cnt_n = '0;
        end else if (bit_end) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five instances with different bit periods and parity
// settings, each checked cycle by cycle against an expected frame bit list.
module tb_uart_tx;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] start = '0;
    logic [7:0]   data [N];
    wire  [N-1:0] tx_v;
    wire  [N-1:0] busy_v;
    wire  [N-1:0] done_v;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
        .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u3 (
        .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data[3]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
    uart_tx #(.CLKS_PER_BIT(434), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u4 (
        .clk(clk), .rst(rst), .tx_start(start[4]), .tx_data(data[4]),
        .tx(tx_v[4]), .tx_busy(busy_v[4]), .tx_done(done_v[4]));

    function automatic int cpb_of(input int k);
        case (k)
            3:       return 2;
            4:       return 434;
            default: return 4;
        endcase
    endfunction

    function automatic bit pe_of(input int k);
        return (k == 1) || (k == 2);
    endfunction

    function automatic bit po_of(input int k);
        return (k == 2);
    endfunction

    // Line levels in transmit order: start, d[0..7], [parity], stop
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit pe, input bit po);
        if (pe) return {1'b1, (^d) ^ po, d, 1'b0};
        else    return {2'b11, d, 1'b0};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    // Called at the negedge where tx_start was raised with byte d; ends at the
    // negedge after tx_done (hold=1) or after a short idle check (hold=0).
    task automatic check_frame(input int k, input logic [7:0] d, input bit poke,
                               input bit hold, input logic [7:0] nd);
        int          cpb;
        int          nb;
        int          b;
        int          c;
        logic [10:0] bits;
        logic [7:0]  rx;
        cpb  = cpb_of(k);
        nb   = pe_of(k) ? 11 : 10;
        bits = frame_bits(d, pe_of(k), po_of(k));
        rx   = 8'd0;
        @(negedge clk);
        if (!hold) start[k] = 1'b0;
        data[k] = 8'($urandom);
        for (int i = 0; i < nb * cpb; i++) begin
            b = i / cpb;
            c = i % cpb;
            chk("tx_bit", k * 100 + b, 32'(tx_v[k]), 32'(bits[b]));
            chk("busy_in_frame", k, 32'(busy_v[k]), 32'd1);
            chk("done_in_frame", k, 32'(done_v[k]), 32'd0);
            if (c == cpb / 2 && b >= 1 && b <= 8) rx[b-1] = tx_v[k];
            if (poke && i == (nb * cpb) / 2) begin
                start[k] = 1'b1;
                data[k]  = 8'hFF;
            end
            if (poke && i == (nb * cpb) / 2 + 1) start[k] = 1'b0;
            if (hold && i == nb * cpb - 1) data[k] = nd;
            @(negedge clk);
        end
        chk("rx_byte", k, 32'(rx), 32'(d));
        chk("end_tx", k, 32'(tx_v[k]), 32'd1);
        chk("end_busy", k, 32'(busy_v[k]), 32'd0);
        chk("end_done", k, 32'(done_v[k]), 32'd1);
        if (!hold) begin
            for (int j = 0; j < 2 * cpb; j++) begin
                @(negedge clk);
                chk("idle_tx", k, 32'(tx_v[k]), 32'd1);
                chk("idle_busy", k, 32'(busy_v[k]), 32'd0);
                chk("idle_done", k, 32'(done_v[k]), 32'd0);
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        start[k] = 1'b1;
        data[k]  = d;
        check_frame(k, d, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] r;
        for (int k = 0; k < N; k++) data[k] = 8'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_tx", k, 32'(tx_v[k]), 32'd1);
            chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
            chk("rst_done", k, 32'(done_v[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        send(0, 8'hA5);

        start[0] = 1'b1;
        data[0]  = 8'h3C;
        check_frame(0, 8'h3C, 1'b1, 1'b0, 8'h00);

        start[0] = 1'b1;
        data[0]  = 8'h55;
        check_frame(0, 8'h55, 1'b0, 1'b1, 8'hAA);
        check_frame(0, 8'hAA, 1'b0, 1'b0, 8'h00);

        // Abort during data bit 3 (frame bit 4), with tx_start high through reset
        start[0] = 1'b1;
        data[0]  = 8'hC3;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_abort_busy", 0, 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_tx", 0, 32'(tx_v[0]), 32'd1);
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("abort_done", 0, 32'(done_v[0]), 32'd0);
        start[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_busy", 0, 32'(busy_v[0]), 32'd0);
            chk("in_rst_done", 0, 32'(done_v[0]), 32'd0);
        end
        start[0] = 1'b0;
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("post_rst_tx", 0, 32'(tx_v[0]), 32'd1);
            chk("post_rst_busy", 0, 32'(busy_v[0]), 32'd0);
            chk("post_rst_done", 0, 32'(done_v[0]), 32'd0);
        end
        send(0, 8'h81);

        send(1, 8'h07);
        send(2, 8'h07);
        for (int j = 0; j < 4; j++) begin
            r = 8'($urandom);
            send(1, r);
            r = 8'($urandom);
            send(2, r);
        end

        for (int j = 0; j < 256; j++) begin
            r = 8'($urandom);
            send(3, r);
        end
        for (int j = 0; j < 8; j++) begin
            r = 8'($urandom);
            send(4, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
